a2b_pkt_scheduler: RTL and testbench

- Packet-atomic round-robin scheduler for Alice's A2B TX channel.
- Shares the single A_TX_pa packet FIFO between two payload requesters: secret-key-length source and PA random-bit source.
- Per packet: builds the 32-bit header, streams the payload, zero-pads to the depth implied by the length code, then re-arbitrates.
- Output format matches what the A2B unpacker expects: header, then exactly real_depth words.

---
 rtl/a2b_pkt_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_a2b_pkt_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2b_pkt_scheduler.sv
// Packet-atomic round-robin scheduler sharing the A_TX_pa FIFO between two payload sources.
// Optional statistics counters are enabled by defining A2B_SCHED_STAT_EN.
module a2b_pkt_scheduler #(
  parameter logic [3:0] TYPE0     = 4'd0,
  parameter logic [3:0] TYPE1     = 4'd1,
  parameter logic [3:0] CODE_257  = 4'd1,
  parameter logic [3:0] CODE_514  = 4'd2,
  parameter logic [3:0] CODE_771  = 4'd3,
  parameter logic [3:0] CODE_1028 = 4'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [10:0] req_len0,
  input  logic [10:0] req_len1,
  output logic [1:0]  grant,
  input  logic        src_valid0,
  input  logic [31:0] src_data0,
  output logic        src_ready0,
  input  logic        src_valid1,
  input  logic [31:0] src_data1,
  output logic        src_ready1,
  output logic        pa_wr_en,
  output logic [31:0] pa_wr_din,
  input  logic        pa_full,
  output logic        pkt_done,
  output logic        pkt_err,
`ifdef A2B_SCHED_STAT_EN
  input  logic        clear_stat,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic [31:0] pad_cnt,
`endif
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StHeader,
    StPayload,
    StPad,
    StDone
  } state_e;

  state_e      state_q;
  logic        rr_ptr_q;
  logic        sel_q;
  logic [10:0] len_q;
  logic [10:0] depth_q;
  logic [10:0] word_cnt_q;
  logic [3:0]  code_q;
  logic [3:0]  type_q;

  logic [10:0] arb_len;
  logic [3:0]  arb_code;
  logic [10:0] arb_depth;
  logic        arb_bad;
  logic [8:0]  hdr_len;
  logic        src_valid_sel;
  logic [31:0] src_data_sel;

  assign arb_len = grant[1] ? req_len1 : req_len0;
  assign arb_bad = (arb_len == 11'd0) || (arb_len > 11'd1024);

  always_comb begin
    arb_code  = CODE_1028;
    arb_depth = 11'd1024;
    if (arb_len <= 11'd256) begin
      arb_code  = CODE_257;
      arb_depth = arb_len;
    end else if (arb_len <= 11'd512) begin
      arb_code  = CODE_514;
      arb_depth = 11'd512;
    end else if (arb_len <= 11'd768) begin
      arb_code  = CODE_771;
      arb_depth = 11'd768;
    end
  end

  // Only the smallest code carries the exact length; larger codes imply the full depth.
  assign hdr_len       = (code_q == CODE_257) ? len_q[8:0] : 9'd0;
  assign src_valid_sel = sel_q ? src_valid1 : src_valid0;
  assign src_data_sel  = sel_q ? src_data1 : src_data0;
  assign busy          = (state_q != StIdle);

  // Write path is combinational so a same-cycle pa_full blocks the write.
  always_comb begin
    pa_wr_en   = 1'b0;
    pa_wr_din  = 32'd0;
    src_ready0 = 1'b0;
    src_ready1 = 1'b0;
    unique case (state_q)
      StHeader: begin
        pa_wr_en  = !pa_full;
        pa_wr_din = pa_full ? 32'd0 : {type_q, code_q, hdr_len, 15'd0};
      end
      StPayload: begin
        src_ready0 = grant[0] & !pa_full;
        src_ready1 = grant[1] & !pa_full;
        pa_wr_en   = src_valid_sel & !pa_full;
        pa_wr_din  = pa_wr_en ? src_data_sel : 32'd0;
      end
      StPad: begin
        pa_wr_en = !pa_full;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= 1'b0;
      sel_q      <= 1'b0;
      len_q      <= 11'd0;
      depth_q    <= 11'd0;
      word_cnt_q <= 11'd0;
      code_q     <= 4'd0;
      type_q     <= 4'd0;
      grant      <= 2'b00;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req != 2'b00) begin
            state_q <= StArb;
            if (req[rr_ptr_q]) begin
              grant <= rr_ptr_q ? 2'b10 : 2'b01;
            end else begin
              grant <= rr_ptr_q ? 2'b01 : 2'b10;
            end
          end
        end
        StArb: begin
          sel_q      <= grant[1];
          len_q      <= arb_len;
          type_q     <= grant[1] ? TYPE1 : TYPE0;
          code_q     <= arb_code;
          depth_q    <= arb_depth;
          word_cnt_q <= 11'd0;
          rr_ptr_q   <= grant[0];  // loser gets priority next time
          if (arb_bad) begin
            pkt_err <= 1'b1;
            grant   <= 2'b00;
            state_q <= StDone;
          end else begin
            state_q <= StHeader;
          end
        end
        StHeader: begin
          if (!pa_full) state_q <= StPayload;
        end
        StPayload: begin
          if (pa_wr_en) begin
            word_cnt_q <= word_cnt_q + 11'd1;
            if (word_cnt_q + 11'd1 == len_q) begin
              if (len_q < depth_q) begin
                state_q <= StPad;
              end else begin
                state_q  <= StDone;
                grant    <= 2'b00;
                pkt_done <= 1'b1;
              end
            end
          end
        end
        StPad: begin
          if (!pa_full) begin
            word_cnt_q <= word_cnt_q + 11'd1;
            if (word_cnt_q + 11'd1 == depth_q) begin
              state_q  <= StDone;
              grant    <= 2'b00;
              pkt_done <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef A2B_SCHED_STAT_EN
  always_ff @(posedge clk) begin
    if (rst || clear_stat) begin
      pkt_cnt0 <= 16'd0;
      pkt_cnt1 <= 16'd0;
      pad_cnt  <= 32'd0;
    end else begin
      if (pkt_done && !sel_q) pkt_cnt0 <= pkt_cnt0 + 16'd1;
      if (pkt_done && sel_q)  pkt_cnt1 <= pkt_cnt1 + 16'd1;
      if (state_q == StPad && !pa_full) pad_cnt <= pad_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_a2b_pkt_scheduler.sv
// Scoreboard bench for a2b_pkt_scheduler: stimulus pushes expected FIFO words and grants,
// a negedge monitor pops and compares.
module tb_a2b_pkt_scheduler;

  localparam logic [3:0] T0 = 4'd2;
  localparam logic [3:0] T1 = 4'd1;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [10:0] req_len0;
  logic [10:0] req_len1;
  logic [1:0]  grant;
  logic        src_valid0;
  logic [31:0] src_data0;
  logic        src_ready0;
  logic        src_valid1;
  logic [31:0] src_data1;
  logic        src_ready1;
  logic        pa_wr_en;
  logic [31:0] pa_wr_din;
  logic        pa_full;
  logic        pkt_done;
  logic        pkt_err;
  logic        busy;

  a2b_pkt_scheduler #(
    .TYPE0(T0),
    .TYPE1(T1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_len0   (req_len0),
    .req_len1   (req_len1),
    .grant      (grant),
    .src_valid0 (src_valid0),
    .src_data0  (src_data0),
    .src_ready0 (src_ready0),
    .src_valid1 (src_valid1),
    .src_data1  (src_data1),
    .src_ready1 (src_ready1),
    .pa_wr_en   (pa_wr_en),
    .pa_wr_din  (pa_wr_din),
    .pa_full    (pa_full),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err),
    .busy       (busy)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  gexp_q[$];
  int          exp_ctr[2];
  int          exp_done  = 0;
  int          exp_err   = 0;
  int          done_seen = 0;
  int          err_seen  = 0;
  int          wr_total  = 0;
  int          cyc       = 0;
  int          glen      = 0;
  int          last_glen = 0;
  logic        prev_wr   = 1'b0;
  logic [1:0]  prev_grant = 2'b00;
  logic        sb_en     = 1'b1;
  logic        bubble_en = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dword(input int n, input int idx);
    return 32'hD000_0000 + 32'(n) * 32'h0010_0000 + 32'(idx);
  endfunction

  // Hand-computed header, then len data words, then pad zero words.
  task automatic push_pkt(input int n, input int len, input int pad, input logic [31:0] hdr);
    exp_q.push_back(hdr);
    for (int i = 0; i < len; i++) exp_q.push_back(dword(n, exp_ctr[n] + i));
    exp_ctr[n] += len;
    for (int i = 0; i < pad; i++) exp_q.push_back(32'd0);
    gexp_q.push_back(n != 0 ? 2'b10 : 2'b01);
    exp_done++;
  endtask

  task automatic push_err(input int n);
    gexp_q.push_back(n != 0 ? 2'b10 : 2'b01);
    exp_err++;
  endtask

  task automatic wait_grant(input int n);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!grant[n] && k < 2000);
    check($sformatf("grant%0d_seen", n), 32'(grant[n]), 32'd1);
  endtask

  task automatic wait_quiet(input string name);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while ((busy || exp_q.size() != 0) && k < 3000);
    check({name, "/drain"}, 32'(exp_q.size()), 32'd0);
    check({name, "/idle"}, 32'(busy), 32'd0);
    check({name, "/done_count"}, 32'(done_seen), 32'(exp_done));
    check({name, "/err_count"}, 32'(err_seen), 32'(exp_err));
    check({name, "/grant_queue"}, 32'(gexp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "/grant"}, 32'(grant), 32'd0);
    check({name, "/busy"}, 32'(busy), 32'd0);
    check({name, "/wr_en"}, 32'(pa_wr_en), 32'd0);
    check({name, "/wr_din"}, pa_wr_din, 32'd0);
    check({name, "/done_err"}, {30'd0, pkt_done, pkt_err}, 32'd0);
    check({name, "/src_ready"}, {30'd0, src_ready0, src_ready1}, 32'd0);
  endtask

  // Sources: always offer the next word of an incrementing sequence.
  initial begin
    int   idx = 0;
    logic take;
    src_valid0 = 1'b0;
    src_data0  = 32'd0;
    forever begin
      @(negedge clk);
      take = src_valid0 && src_ready0;
      @(posedge clk);
      #1;
      if (take) idx++;
      src_data0  = dword(0, idx);
      src_valid0 = !(bubble_en && (cyc % 3 == 1));
    end
  end

  initial begin
    int   idx = 0;
    logic take;
    src_valid1 = 1'b0;
    src_data1  = 32'd0;
    forever begin
      @(negedge clk);
      take = src_valid1 && src_ready1;
      @(posedge clk);
      #1;
      if (take) idx++;
      src_data1  = dword(1, idx);
      src_valid1 = !(bubble_en && (cyc % 3 == 1));
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (pa_wr_en === 1'b1) begin
        wr_total++;
        if (sb_en) begin
          check("fifo_write_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("fifo_word", pa_wr_din, exp_q.pop_front());
        end
      end
      if (pa_full) check("blocked_while_full", {29'd0, pa_wr_en, src_ready0, src_ready1}, 32'd0);
      if (grant != 2'b00) begin
        if (prev_grant == 2'b00) begin
          check("grant_expected", 32'(gexp_q.size() != 0), 32'd1);
          if (gexp_q.size() != 0) check("grant_order", 32'(grant), 32'(gexp_q.pop_front()));
        end
        glen++;
      end else if (prev_grant != 2'b00) begin
        last_glen = glen;
        glen      = 0;
      end
      if (pkt_err === 1'b1) begin
        err_seen++;
        check("err_grant_one_cycle", 32'(last_glen), 32'd1);
      end
      if (pkt_done === 1'b1) begin
        done_seen++;
        check("done_after_last_word", 32'(prev_wr), 32'd1);
      end
      prev_wr    = (pa_wr_en === 1'b1);
      prev_grant = grant;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    int k;
    exp_ctr[0] = 0;
    exp_ctr[1] = 0;
    rst      = 1'b1;
    req      = 2'b00;
    req_len0 = 11'd0;
    req_len1 = 11'd0;
    pa_full  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Both requesting from reset: 0,1,0,1 with no interleave.
    push_pkt(0, 3, 0, 32'h2101_8000);
    push_pkt(1, 2, 0, 32'h1101_0000);
    push_pkt(0, 3, 0, 32'h2101_8000);
    push_pkt(1, 2, 0, 32'h1101_0000);
    req_len0 = 11'd3;
    req_len1 = 11'd2;
    req      = 2'b11;
    wait_grant(0);
    wait_grant(1);
    wait_grant(0);
    wait_grant(1);
    req = 2'b00;
    wait_quiet("rr_pair");

    // Requester 0 alone, len 5.
    push_pkt(0, 5, 0, 32'h2102_8000);
    req_len0 = 11'd5;
    req[0]   = 1'b1;
    wait_grant(0);
    req[0] = 1'b0;
    wait_quiet("len5");

    // Requester 1, len 300: 300 data + 212 pad.
    w0 = wr_total;
    push_pkt(1, 300, 212, 32'h1200_0000);
    req_len1 = 11'd300;
    req[1]   = 1'b1;
    wait_grant(1);
    req[1] = 1'b0;
    wait_quiet("len300");
    check("len300_writes", 32'(wr_total - w0), 32'd513);

    // Illegal lengths; rr_ptr is 0 here, so a stuck pointer would grant 0 first below.
    w0 = wr_total;
    push_err(0);
    req_len0 = 11'd1025;
    req[0]   = 1'b1;
    wait_grant(0);
    req[0] = 1'b0;
    wait_quiet("len1025");
    push_err(1);
    push_pkt(0, 2, 0, 32'h2101_0000);
    req_len1 = 11'd0;
    req_len0 = 11'd2;
    req      = 2'b11;
    wait_grant(1);
    req[1] = 1'b0;
    wait_grant(0);
    req[0] = 1'b0;
    wait_quiet("len0");
    check("err_path_writes", 32'(wr_total - w0), 32'd3);

    // Backpressure at header and mid-payload, with source bubbles.
    bubble_en = 1'b1;
    w0 = wr_total;
    push_pkt(0, 10, 0, 32'h2105_0000);
    req_len0 = 11'd10;
    req[0]   = 1'b1;
    wait_grant(0);
    req[0]  = 1'b0;
    pa_full = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    pa_full = 1'b0;
    k = 0;
    while (wr_total < w0 + 4 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    pa_full = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    pa_full = 1'b0;
    wait_quiet("full");
    check("full_writes", 32'(wr_total - w0), 32'd11);
    bubble_en = 1'b0;

    // Reset during PAD of a 600-word packet.
    sb_en = 1'b0;
    gexp_q.push_back(2'b01);
    w0 = wr_total;
    req_len0 = 11'd600;
    req[0]   = 1'b1;
    wait_grant(0);
    req[0] = 1'b0;
    k = 0;
    while (wr_total < w0 + 611 && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("reached_pad", 32'(wr_total >= w0 + 611), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("mid_pad_reset");
    rst        = 1'b0;
    sb_en      = 1'b1;
    exp_ctr[0] += 600;
    push_pkt(0, 4, 0, 32'h2102_0000);
    req_len0 = 11'd4;
    req[0]   = 1'b1;
    wait_grant(0);
    req[0] = 1'b0;
    wait_quiet("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
